reg_bus_arbiter: RTL and testbench
==================================

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, the number of register-bus requesters (>=2).
REQ-002 SHALL have parameter TimeoutCycles, default 256, the cycles a granted access may wait for ready; 0 disables the timeout.
REQ-003 SHALL have ports clk_i (input, 1, the only clock) and rst_i (input, 1); reset is asynchronous and active-high.
REQ-004 SHALL have port req_i, input, reg_req_t [NumReq], upstream requests (addr, write, wdata, wstrb, valid).
REQ-005 SHALL have port rsp_o, output, reg_rsp_t [NumReq], upstream responses (rdata, error, ready).
REQ-006 SHALL have port req_o, output, reg_req_t, the single shared downstream request.
REQ-007 SHALL have port rsp_i, input, reg_rsp_t, the downstream response (ready may be combinational on valid).
REQ-008 SHALL have port busy_o, output, 1, high while in ACTIVE.
REQ-009 SHALL have port timeout_o, output, 1, a one-cycle pulse on timeout abort.

Function
REQ-010 SHALL implement FSM states IDLE and ACTIVE; registered: state, gnt_idx, rr_ptr, wait_cnt.
REQ-011 IDLE: when any req_i[k].valid, SHALL register gnt_idx = first valid index at or after rr_ptr (modulo NumReq) and go to ACTIVE next cycle; otherwise stay in IDLE.
REQ-012 IDLE: req_o SHALL be all-zero (valid=0), and every rsp_o[k] SHALL be ready=0, error=0, rdata=0.
REQ-013 ACTIVE: req_o SHALL equal req_i[gnt_idx] combinationally; rsp_o[gnt_idx] SHALL equal rsp_i; all other rsp_o SHALL be zero.
REQ-014 ACTIVE with rsp_i.ready=1: SHALL go to IDLE, set rr_ptr = (gnt_idx+1) mod NumReq, clear wait_cnt.
REQ-015 ACTIVE with rsp_i.ready=0: wait_cnt SHALL increment by 1 per cycle, saturating at TimeoutCycles (width $clog2(TimeoutCycles+1), minimum 1 bit).
REQ-016 ACTIVE with TimeoutCycles!=0, wait_cnt==TimeoutCycles and rsp_i.ready=0: SHALL drive req_o.valid=0; rsp_o[gnt_idx] ready=1, error=1, rdata=0; pulse timeout_o; go to IDLE; advance rr_ptr as in REQ-014.
REQ-017 ACTIVE with req_i[gnt_idx].valid=0 (requester withdrew): SHALL go to IDLE with no response, advance rr_ptr, clear wait_cnt.
REQ-018 Latency: request valid in cycle n (IDLE) SHALL appear on req_o in cycle n+1; with zero-wait downstream the response returns in n+1; min occupancy 2 cycles per access.
REQ-019 Simultaneous requests SHALL be served round-robin; no requester is granted twice while another is continuously valid.
REQ-020 Requests arriving during ACTIVE SHALL be held off (ready=0) until a later IDLE grant.
REQ-021 rsp_i.ready and timeout in the same cycle: ready SHALL win (normal response, no timeout_o).

Reset
REQ-022 On rst_i=1: state=IDLE, gnt_idx=0, rr_ptr=0, wait_cnt=0, timeout_o=0, busy_o=0, all outputs per REQ-012, immediately and asynchronously, including mid-ACTIVE.
REQ-023 An access in flight at reset SHALL be dropped without any upstream response.

Structure
REQ-024 reg_req_t and reg_rsp_t SHALL come from core_v_mcu_pkg; default timeout constant REG_ARB_TIMEOUT_CYCLES SHALL be added there.
REQ-025 The rotating first-valid search SHALL be one sub-module, reg_arb_rr_pick (combinational: valid vector, pointer -> index, any).

Verification
REQ-026 Single: req 0 read addr 0x1000, downstream ready same cycle rdata 0xA5 -> req_o.valid in cycle 1 only, rsp_o[0] ready=1 rdata=0xA5, rr_ptr=1.
REQ-027 Contention: req 0 and 1 continuously valid, zero-wait slave -> grants 0,1,0,1 every 2 cycles.
REQ-028 Timeout: TimeoutCycles=4, slave never ready -> rsp_o[0] ready=1 error=1 rdata=0 and timeout_o pulse exactly 5 cycles after grant.
REQ-029 Ready on the timeout cycle (TimeoutCycles=4, ready at wait_cnt=4) -> normal response, error=rsp_i.error, no timeout_o.
REQ-030 Reset mid-access: rst_i asserted while ACTIVE with 3 wait cycles -> req_o.valid=0 immediately; after release the first grant goes to index 0.
REQ-031 Withdrawal: req 1 granted, valid dropped before ready -> IDLE next cycle, no rsp_o[1].ready, rr_ptr=0.

Source files
------------

// File: rtl/core_v_mcu_pkg.sv
// Shared register-bus types and defaults.
// Used by the register-bus arbiter and its requesters.
package core_v_mcu_pkg;

  localparam int unsigned REG_ADDR_W = 32;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_STRB_W = REG_DATA_W / 8;

  localparam int unsigned REG_ARB_TIMEOUT_CYCLES = 256;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic                  write;
    logic [REG_DATA_W-1:0] wdata;
    logic [REG_STRB_W-1:0] wstrb;
    logic                  valid;
  } reg_req_t;

  typedef struct packed {
    logic [REG_DATA_W-1:0] rdata;
    logic                  error;
    logic                  ready;
  } reg_rsp_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_ACTIVE
  } arb_state_e;

endpackage

// File: rtl/reg_arb_rr_pick.sv
// Rotating first-valid search: lowest valid index
// at or after ptr_i, wrapping modulo N.
module reg_arb_rr_pick #(
  parameter  int unsigned N    = 2,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    valid_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [2*N-1:0]  dbl;
  logic [N-1:0]    rot;
  logic [IdxW-1:0] off;
  logic [IdxW:0]   sum;

  // Rotate so bit 0 is ptr_i, take the lowest set bit,
  // then map the offset back to an absolute index.
  always_comb begin
    dbl   = {valid_i, valid_i} >> ptr_i;
    rot   = dbl[N-1:0];
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IdxW'(i);
    end
    sum   = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IdxW+1)'(N)) sum = sum - (IdxW+1)'(N);
    idx_o = sum[IdxW-1:0];
    any_o = |valid_i;
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter folding NumReq register-bus
// requesters onto one downstream port, with timeout.
module reg_bus_arbiter
  import core_v_mcu_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = REG_ARB_TIMEOUT_CYCLES
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  reg_req_t req_i [NumReq],
  output reg_rsp_t rsp_o [NumReq],
  output reg_req_t req_o,
  input  reg_rsp_t rsp_i,
  output logic     busy_o,
  output logic     timeout_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW =
    (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  logic [NumReq-1:0] valid_vec;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;
  logic [IdxW-1:0]   ptr_next;
  reg_req_t          gnt_req;

  // Collect requester valids for the picker.
  always_comb begin
    valid_vec = '0;
    for (int k = 0; k < NumReq; k++) begin
      valid_vec[k] = req_i[k].valid;
    end
  end

  reg_arb_rr_pick #(
    .N(NumReq)
  ) u_pick (
    .valid_i(valid_vec),
    .ptr_i  (rr_ptr_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Next-state and output decode; ready beats timeout,
  // a withdrawn request ends the access silently.
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    req_o      = '0;
    busy_o     = 1'b0;
    timeout_o  = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      rsp_o[k] = '0;
    end
    gnt_req  = req_i[gnt_idx_q];
    ptr_next = (gnt_idx_q == LastIdx) ? '0
             : gnt_idx_q + IdxW'(1);
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          gnt_idx_d  = pick_idx;
          wait_cnt_d = '0;
          state_d    = ARB_ACTIVE;
        end
      end
      ARB_ACTIVE: begin
        busy_o = 1'b1;
        if (!gnt_req.valid) begin
          req_o      = gnt_req;
          state_d    = ARB_IDLE;
          rr_ptr_d   = ptr_next;
          wait_cnt_d = '0;
        end else if (rsp_i.ready) begin
          req_o            = gnt_req;
          rsp_o[gnt_idx_q] = rsp_i;
          state_d          = ARB_IDLE;
          rr_ptr_d         = ptr_next;
          wait_cnt_d       = '0;
        end else if (TimeoutCycles != 0 &&
                     wait_cnt_q == CntMax) begin
          rsp_o[gnt_idx_q].ready = 1'b1;
          rsp_o[gnt_idx_q].error = 1'b1;
          timeout_o              = 1'b1;
          state_d                = ARB_IDLE;
          rr_ptr_d               = ptr_next;
          wait_cnt_d             = '0;
        end else begin
          req_o = gnt_req;
          if (wait_cnt_q != CntMax) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State register; reset drops any access in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      gnt_idx_q  <= '0;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: vector table, corner
// sequences and a randomized run against a reference model.
module tb_reg_bus_arbiter;
  import core_v_mcu_pkg::*;

  localparam int N = 2;
  localparam int T = 4;

  logic     clk;
  logic     rst;
  reg_req_t req_i [N];
  reg_rsp_t rsp_o [N];
  reg_req_t req_o;
  reg_rsp_t rsp_i;
  logic     busy;
  logic     tmo;

  int n_cmp = 0;
  int n_bad = 0;

  reg_bus_arbiter #(
    .NumReq       (N),
    .TimeoutCycles(T)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req_i),
    .rsp_o    (rsp_o),
    .req_o    (req_o),
    .rsp_i    (rsp_i),
    .busy_o   (busy),
    .timeout_o(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0, v1, rdy, err;
    logic        ev;
    logic [31:0] ea;
    logic        e0r, e0e;
    logic [31:0] e0d;
    logic        e1r, e1e;
    logic [31:0] e1d;
    logic        eb, eto;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    logic v0, logic v1, logic rdy, logic err, logic ev,
    logic [31:0] ea, logic e0r, logic e0e,
    logic [31:0] e0d, logic e1r, logic e1e,
    logic [31:0] e1d, logic eb, logic eto);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.rdy = rdy; v.err = err;
    v.ev = ev; v.ea = ea;
    v.e0r = e0r; v.e0e = e0e; v.e0d = e0d;
    v.e1r = e1r; v.e1e = e1e; v.e1d = e1d;
    v.eb = eb; v.eto = eto;
    return v;
  endfunction

  task automatic drive_fix(logic v0, logic v1,
                           logic rdy, logic err);
    for (int k = 0; k < N; k++) begin
      req_i[k].addr  = 32'h1000 + 32'(k) * 32'h100;
      req_i[k].write = 1'b0;
      req_i[k].wdata = '0;
      req_i[k].wstrb = '0;
    end
    req_i[0].valid = v0;
    req_i[1].valid = v1;
    rsp_i.rdata = 32'hA5;
    rsp_i.error = err;
    rsp_i.ready = rdy;
  endtask

  // reference model state
  int owner;
  int waited;
  int ptr;
  logic [N-1:0] done_k;
  reg_req_t ereq;
  reg_rsp_t ersp [N];
  logic ebusy, eto;

  // Expected outputs for the current inputs, then advance.
  task automatic model_step();
    int nxt_owner, nxt_wait, nxt_ptr;
    ereq = '0;
    for (int k = 0; k < N; k++) ersp[k] = '0;
    eto = 1'b0;
    ebusy = (owner >= 0);
    nxt_owner = owner;
    nxt_wait = waited;
    nxt_ptr = ptr;
    done_k = '0;
    if (owner >= 0) begin
      if (!req_i[owner].valid) begin
        ereq = req_i[owner];
        nxt_owner = -1;
        nxt_ptr = (owner + 1) % N;
      end else if (rsp_i.ready) begin
        ereq = req_i[owner];
        ersp[owner] = rsp_i;
        done_k[owner] = 1'b1;
        nxt_owner = -1;
        nxt_ptr = (owner + 1) % N;
      end else if (waited == T) begin
        ersp[owner].ready = 1'b1;
        ersp[owner].error = 1'b1;
        eto = 1'b1;
        done_k[owner] = 1'b1;
        nxt_owner = -1;
        nxt_ptr = (owner + 1) % N;
      end else begin
        ereq = req_i[owner];
        nxt_wait = waited + 1;
      end
    end else begin
      for (int off = N - 1; off >= 0; off--) begin
        if (req_i[(ptr + off) % N].valid) begin
          nxt_owner = (ptr + off) % N;
        end
      end
      nxt_wait = 0;
    end
    owner = nxt_owner;
    waited = nxt_wait;
    ptr = nxt_ptr;
  endtask

  task automatic rand_req(int k);
    req_i[k].addr  = $urandom;
    req_i[k].write = 1'($urandom_range(1));
    req_i[k].wdata = $urandom;
    req_i[k].wstrb = 4'($urandom_range(15));
  endtask

  initial begin
    rst = 1'b1;
    drive_fix(0, 0, 0, 0);

    tbl[0]  = mk(1,1,1,0, 0,0, 0,0,0, 0,0,0, 0,0);
    tbl[1]  = mk(1,1,1,0, 1,32'h1000, 1,0,32'hA5,
                 0,0,0, 1,0);
    tbl[2]  = mk(1,1,1,0, 0,0, 0,0,0, 0,0,0, 0,0);
    tbl[3]  = mk(1,1,1,0, 1,32'h1100, 0,0,0,
                 1,0,32'hA5, 1,0);
    tbl[4]  = mk(1,1,1,0, 0,0, 0,0,0, 0,0,0, 0,0);
    tbl[5]  = mk(1,1,1,0, 1,32'h1000, 1,0,32'hA5,
                 0,0,0, 1,0);
    tbl[6]  = mk(1,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0);
    for (int i = 7; i <= 10; i++)
      tbl[i] = mk(1,0,0,0, 1,32'h1000, 0,0,0,
                  0,0,0, 1,0);
    tbl[11] = mk(1,0,0,0, 0,0, 1,1,0, 0,0,0, 1,1);
    tbl[12] = mk(1,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0);
    for (int i = 13; i <= 16; i++)
      tbl[i] = mk(1,0,0,0, 1,32'h1000, 0,0,0,
                  0,0,0, 1,0);
    tbl[17] = mk(1,0,1,1, 1,32'h1000, 1,1,32'hA5,
                 0,0,0, 1,0);

    tick();
    tick();
    #1;
    chk("rst_valid", 128'(req_o.valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rsp0", 128'(rsp_o[0]), 128'(0));
    chk("rst_tmo", 128'(tmo), 128'(0));
    tick();
    rst = 1'b0;

    // table-driven: contention, timeout, ready-on-timeout
    for (int i = 0; i < 18; i++) begin
      drive_fix(tbl[i].v0, tbl[i].v1, tbl[i].rdy,
                tbl[i].err);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i),
          128'(req_o.valid), 128'(tbl[i].ev));
      chk($sformatf("tbl%0d_addr", i),
          128'(req_o.addr), 128'(tbl[i].ea));
      chk($sformatf("tbl%0d_r0", i),
          128'({rsp_o[0].ready, rsp_o[0].error,
                rsp_o[0].rdata}),
          128'({tbl[i].e0r, tbl[i].e0e, tbl[i].e0d}));
      chk($sformatf("tbl%0d_r1", i),
          128'({rsp_o[1].ready, rsp_o[1].error,
                rsp_o[1].rdata}),
          128'({tbl[i].e1r, tbl[i].e1e, tbl[i].e1d}));
      chk($sformatf("tbl%0d_busy", i),
          128'(busy), 128'(tbl[i].eb));
      chk($sformatf("tbl%0d_tmo", i),
          128'(tmo), 128'(tbl[i].eto));
      tick();
    end

    // reset mid-access (rr_ptr is 1 here)
    drive_fix(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_valid", 128'(req_o.valid), 128'(1));
    chk("mid_addr", 128'(req_o.addr), 128'(32'h1100));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(req_o.valid), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_r1", 128'(rsp_o[1].ready), 128'(0));
    tick();
    rst = 1'b0;
    drive_fix(1, 1, 1, 0);
    tick();
    @(negedge clk);
    chk("post_rst_addr", 128'(req_o.addr), 128'(32'h1000));
    chk("post_rst_r0", 128'(rsp_o[0].ready), 128'(1));
    chk("post_rst_r1", 128'(rsp_o[1].ready), 128'(0));
    tick();

    // withdrawal (rr_ptr is 1 here)
    drive_fix(0, 1, 0, 0);
    tick();
    @(negedge clk);
    chk("wd_addr", 128'(req_o.addr), 128'(32'h1100));
    tick();
    drive_fix(0, 0, 1, 0);
    @(negedge clk);
    chk("wd_r1", 128'(rsp_o[1].ready), 128'(0));
    chk("wd_busy", 128'(busy), 128'(1));
    tick();
    drive_fix(1, 1, 0, 0);
    @(negedge clk);
    chk("wd_idle", 128'(busy), 128'(0));
    tick();
    @(negedge clk);
    chk("wd_ptr0", 128'(req_o.addr), 128'(32'h1000));
    tick();

    // randomized run against the reference model
    rst = 1'b1;
    drive_fix(0, 0, 0, 0);
    tick();
    rst = 1'b0;
    owner = -1;
    waited = 0;
    ptr = 0;
    done_k = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (done_k[k]) begin
          rand_req(k);
          req_i[k].valid = 1'($urandom_range(1));
        end else if (!req_i[k].valid) begin
          if ($urandom_range(2) == 0) begin
            rand_req(k);
            req_i[k].valid = 1'b1;
          end
        end else if ($urandom_range(15) == 0) begin
          req_i[k].valid = 1'b0;
        end
      end
      rsp_i.ready = ($urandom_range(3) == 0);
      rsp_i.error = 1'($urandom_range(1));
      rsp_i.rdata = $urandom;
      @(negedge clk);
      model_step();
      chk($sformatf("rnd%0d_req", c),
          128'(req_o), 128'(ereq));
      chk($sformatf("rnd%0d_r0", c),
          128'(rsp_o[0]), 128'(ersp[0]));
      chk($sformatf("rnd%0d_r1", c),
          128'(rsp_o[1]), 128'(ersp[1]));
      chk($sformatf("rnd%0d_busy", c),
          128'(busy), 128'(ebusy));
      chk($sformatf("rnd%0d_tmo", c),
          128'(tmo), 128'(eto));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
